// File: rtl/alu8_pkg.sv
// Shared opcodes, sequencer state encoding and opcode helpers for the alu8 datapath.
package alu8_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_SHR  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } seqState_t;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alu8.sv
// Combinational 8-bit ALU: add/sub share one adder, single-bit shifts, logic ops and pass.
module alu8
  import alu8_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] op,
  output logic [7:0] y,
  output logic       z,
  output logic       c,
  output logic       v
);

  logic [7:0] addB;
  logic       addCin;
  logic [8:0] sum;

  // SUB is A + ~B + 1; carry out of that sum is the inverse of the borrow.
  assign addB   = (op == OP_SUB) ? ~b : b;
  assign addCin = (op == OP_SUB);
  assign sum    = {1'b0, a} + {1'b0, addB} + {8'd0, addCin};

  always_comb begin
    y = a;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        y = sum[7:0];
        c = sum[8];
        v = (a[7] == addB[7]) && (sum[7] != a[7]);
      end
      OP_SUB: begin
        y = sum[7:0];
        c = ~sum[8];
        v = (a[7] == addB[7]) && (sum[7] != a[7]);
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_SHL: begin
        y = {a[6:0], 1'b0};
        c = a[7];
      end
      OP_SHR: begin
        y = {1'b0, a[7:1]};
        c = a[0];
      end
      default: y = a;
    endcase
  end

  assign z = (y == 8'd0);

endmodule

// File: rtl/alu8_cmd_sequencer.sv
// Command front-end for alu8: handshaked commands in, multi-bit shifts iterated, registered results out.
//   state    | meaning
//   ST_IDLE  | waiting for a command, cmd_ready high
//   ST_EXEC  | single-cycle ALU op from operand registers
//   ST_SHIFT | one bit shifted per cycle until the count runs out
//   ST_DONE  | result presented, waiting for res_ready
module alu8_cmd_sequencer
  import alu8_pkg::*;
#(
  parameter int         CNT_W    = 3,
  parameter logic [7:0] ACC_INIT = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic             cmd_use_acc,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_y,
  output logic             res_z,
  output logic             res_c,
  output logic             res_v,
  output logic [7:0]       acc,
  output logic             busy
);

  seqState_t        state;
  logic [2:0]       opReg;
  logic [7:0]       aReg;
  logic [7:0]       bReg;
  logic [CNT_W-1:0] remaining;

  logic [2:0] aluOp;
  logic [7:0] aluY;
  logic       aluZ, aluC, aluV;

  // A zero-count shift lands in EXEC and must return A untouched.
  assign aluOp = ((state == ST_EXEC) && is_shift(opReg)) ? OP_PASS : opReg;

  alu8 uAlu (
    .a  (aReg),
    .b  (bReg),
    .op (aluOp),
    .y  (aluY),
    .z  (aluZ),
    .c  (aluC),
    .v  (aluV)
  );

  assign cmd_ready = (state == ST_IDLE) && !rst;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      opReg     <= OP_PASS;
      aReg      <= 8'd0;
      bReg      <= 8'd0;
      remaining <= '0;
      res_valid <= 1'b0;
      res_y     <= 8'd0;
      res_z     <= 1'b0;
      res_c     <= 1'b0;
      res_v     <= 1'b0;
      acc       <= ACC_INIT;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            opReg     <= cmd_op;
            aReg      <= cmd_use_acc ? acc : cmd_a;
            bReg      <= cmd_b;
            remaining <= cmd_cnt;
            state     <= (is_shift(cmd_op) && (cmd_cnt != '0)) ? ST_SHIFT : ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_y     <= aluY;
          res_z     <= aluZ;
          res_c     <= aluC;
          res_v     <= aluV;
          acc       <= aluY;
          res_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_SHIFT: begin
          aReg      <= aluY;
          remaining <= remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            res_y     <= aluY;
            res_z     <= aluZ;
            res_c     <= aluC;
            res_v     <= 1'b0;
            acc       <= aluY;
            res_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu8_cmd_sequencer.md
Name: alu8_cmd_sequencer

Overview:
Sequential front-end that drives the existing combinational alu8 (instantiated inside). It accepts ALU commands over a valid/ready handshake and optionally sources operand A from an internal accumulator. It iterates multi-bit shifts through the single-bit shifter, then returns registered result and flags over a second valid/ready handshake. It sits between a command master (bus slave or test sequencer) and the datapath ALU.

Parameters:
CNT_W, 3, width of shift-count field; maximum shift = 2^CNT_W-1
ACC_INIT, 8'h00, accumulator value after reset

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept command
cmd_op  in  3  ALU opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 PASS
cmd_a  in  8  operand A (ignored when cmd_use_acc=1)
cmd_b  in  8  operand B
cmd_use_acc  in  1  take operand A from accumulator
cmd_cnt  in  CNT_W  shift count for SHL/SHR; ignored for other ops
res_valid  out  1  result available
res_ready  in  1  result consumer ready
res_y  out  8  result
res_z  out  1  zero flag
res_c  out  1  carry/borrow/shifted-out bit
res_v  out  1  signed overflow
acc  out  8  current accumulator value
busy  out  1  state != IDLE

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE; res_valid=0, res_y=0, res_z=0, res_c=0, res_v=0, acc=ACC_INIT, busy=0. cmd_ready=0 while rst=1.
- cmd_ready = (state==IDLE) && !rst, combinational. Accept = cmd_valid && cmd_ready at a rising edge.
- States: IDLE, EXEC, SHIFT, DONE.
- IDLE -> on accept, latch op, A (cmd_a or acc), B, cnt into operand registers:
  - SHL/SHR with cnt>=1 -> SHIFT with remaining = cnt.
  - All other ops, and shifts with cnt=0 -> EXEC.
- EXEC (1 cycle): alu8 is driven from operand registers. At the next edge, capture Y/Z/C/V into result registers, set acc=Y, set res_valid=1, go to DONE. Accept-to-res_valid latency = 1 edge.
  - Shift with cnt=0: ALU forced to PASS; Y=A, C=0, V=0.
- SHIFT: each edge loads operand A <= alu8.Y, records alu8.C as carry, and decrements remaining.
  - When remaining reaches 1, capture Y/C at that edge, with Z=(Y==0) and V=0; set acc, res_valid=1, go to DONE.
  - Latency = cnt edges after accept.
  - res_c = last bit shifted out: SHL takes A[8-cnt], SHR takes A[cnt-1].
- DONE: result registers held stable. cmd_ready=0. When res_valid && res_ready at an edge: res_valid<=0, go to IDLE. The next command can be accepted no earlier than the following edge.
- Flags for ADD/SUB/logic/PASS are exactly alu8's outputs: SUB C=1 iff A<B unsigned; logic ops C=V=0.
- acc updates only on result capture, never on handshake.
- res_y/flags may hold stale values while res_valid=0; the consumer must not sample them then.
- Reset mid-operation (EXEC, SHIFT or DONE): the operation is aborted and its result discarded; the reset values above apply at that edge.
- cmd_valid during non-IDLE states is ignored; the command is not consumed.

Decomposition:
- Shared package alu8_pkg:
  - opcode localparams OP_ADD..OP_PASS
  - state encoding for IDLE/EXEC/SHIFT/DONE
  - helper is_shift(op)
- One sub-module: the existing alu8, instantiated once. It is the only arithmetic in the block; no duplicate adders.

Test Plan:
- Reset held 3 cycles, then released -> res_valid=0, acc=8'h00, busy=0; cmd_ready 0 during reset, 1 on the first cycle after release.
- ADD A=8'hFF B=8'h01, res_ready=1 -> one edge after accept: res_y=8'h00, Z=1, C=1, V=0; acc=8'h00; back in IDLE one edge after handshake.
- ADD A=8'h7F B=8'h01 -> Y=8'h80, V=1, C=0. Then SUB use_acc=1, B=8'h01 -> Y=8'h7F, V=1, C=0; acc=8'h7F.
- SHL cnt=3 A=8'hB1 -> res_valid exactly 3 edges after accept, Y=8'h88, C=1, V=0. SHR cnt=4 A=8'h38 -> Y=8'h03, C=1. SHL cnt=0 A=8'h5A -> Y=8'h5A, C=0, one edge latency.
- Backpressure: res_ready=0 for 5 cycles after AND A=8'hF0 B=8'h0F -> res_y=8'h00, Z=1 held stable; cmd_ready=0; a concurrent cmd_valid is not consumed; accepted only after res_ready=1.
- rst pulsed during SHIFT of SHR cnt=7 A=8'h80 -> next cycle res_valid=0, acc=8'h00, IDLE; no result ever presented for the aborted command.
